relax_scheduler: RTL and testbench

- Frame-level sequencer for the chain-simulation array.
- Each frame it latches a mouse sample and runs ITERS_PER_FRAME constraint-relaxation passes over NUM_CORES cores.
- Passes use red/black core phasing, so neighbouring cores never update their boundary nodes in the same cycle.
- It drives per-core enables and a one-hot node strobe, then signals frame completion to the display/readout side.

---
 rtl/relax_scheduler_if.sv | 32 +++
 rtl/relax_scheduler.sv | 153 +++++++++++++++
 tb/tb_relax_scheduler.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/relax_scheduler_if.sv
// Handshake/bus bundle for relax_scheduler: frame request, hold, mouse
// sample in, latched mouse, strobes and frame status out.
interface relax_scheduler_if #(
  parameter int NUM_CORES      = 4,
  parameter int NODES_PER_CORE = 5
);
  logic                      frame_start;
  logic                      hold;
  logic [31:0]               mouse_x_in;
  logic [31:0]               mouse_y_in;
  logic [31:0]               mouse_x;
  logic [31:0]               mouse_y;
  logic [NUM_CORES-1:0]      core_en;
  logic [NODES_PER_CORE-1:0] node_sel;
  logic                      phase;
  logic [7:0]                iter_count;
  logic                      frame_busy;
  logic                      frame_done;
  logic                      overrun;

  modport master (
    output frame_start, hold, mouse_x_in, mouse_y_in,
    input  mouse_x, mouse_y, core_en, node_sel, phase, iter_count,
           frame_busy, frame_done, overrun
  );

  modport slave (
    input  frame_start, hold, mouse_x_in, mouse_y_in,
    output mouse_x, mouse_y, core_en, node_sel, phase, iter_count,
           frame_busy, frame_done, overrun
  );
endinterface

// File: rtl/relax_scheduler.sv
// Frame sequencer for the chain-simulation array: latches a mouse sample,
// then walks ITERS_PER_FRAME red/black relaxation passes, strobing one node
// at a time across the cores of the active phase.
module relax_scheduler #(
  parameter int NUM_CORES       = 4,
  parameter int NODES_PER_CORE  = 5,
  parameter int ITERS_PER_FRAME = 8,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic              clk,
  input  logic              reset,
  relax_scheduler_if.slave  bus
);

  typedef enum logic [2:0] {IDLE, LATCH, STEP, SETTLE, DONE} state_t;

  state_t      state, state_n;
  logic [4:0]  node, node_n;
  logic        phase_q, phase_n;
  logic [7:0]  iter, iter_n;
  logic [3:0]  settle_cnt, settle_n;
  logic [31:0] mx_q, my_q;
  logic        overrun_q;

  logic        last_node;
  logic        adv_done;
  logic [4:0]  adv_node;
  logic        adv_phase;
  logic [7:0]  adv_iter;
  logic        do_adv;
  logic        strobe;
  logic [NUM_CORES-1:0] mask;

  // Advance step: node innermost, then phase, then pass index.
  always_comb begin
    last_node = (int'(node) == NODES_PER_CORE - 1);
    adv_node  = last_node ? '0 : node + 5'd1;
    adv_phase = last_node ? ~phase_q : phase_q;
    adv_iter  = (last_node && phase_q) ? iter + 8'd1 : iter;
    adv_done  = last_node && phase_q && (int'(iter) == ITERS_PER_FRAME - 1);
  end

  // Next-state and counter update; hold freezes everything in STEP/SETTLE.
  always_comb begin
    state_n  = state;
    node_n   = node;
    phase_n  = phase_q;
    iter_n   = iter;
    settle_n = settle_cnt;
    do_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.frame_start) state_n = LATCH;
      end
      LATCH: begin
        node_n   = '0;
        phase_n  = 1'b0;
        iter_n   = '0;
        settle_n = '0;
        state_n  = STEP;
      end
      STEP: begin
        if (!bus.hold) begin
          if (SETTLE_CYCLES > 0) begin
            state_n  = SETTLE;
            settle_n = '0;
          end else begin
            do_adv = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (!bus.hold) begin
          if (int'(settle_cnt) == SETTLE_CYCLES - 1) do_adv = 1'b1;
          else settle_n = settle_cnt + 4'd1;
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
    // Counters are zeroed on DONE entry so iter_count/phase read 0 in IDLE.
    if (do_adv) begin
      if (adv_done) begin
        state_n = DONE;
        node_n  = '0;
        phase_n = 1'b0;
        iter_n  = '0;
      end else begin
        state_n = STEP;
        node_n  = adv_node;
        phase_n = adv_phase;
        iter_n  = adv_iter;
      end
    end
  end

  // State and counter registers; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= IDLE;
      node       <= '0;
      phase_q    <= 1'b0;
      iter       <= '0;
      settle_cnt <= '0;
    end else begin
      state      <= state_n;
      node       <= node_n;
      phase_q    <= phase_n;
      iter       <= iter_n;
      settle_cnt <= settle_n;
    end
  end

  // Mouse sample is captured only in LATCH and held across IDLE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mx_q <= '0;
      my_q <= '0;
    end else if (state == LATCH) begin
      mx_q <= bus.mouse_x_in;
      my_q <= bus.mouse_y_in;
    end
  end

  // Sticky overrun: a request seen anywhere outside IDLE.
  always_ff @(posedge clk) begin
    if (!reset) overrun_q <= 1'b0;
    else if (bus.frame_start && state != IDLE) overrun_q <= 1'b1;
  end

  // Phase mask: cores whose index parity matches the current phase.
  always_comb begin
    mask = '0;
    for (int unsigned c = 0; c < NUM_CORES; c++) mask[c] = (c[0] == phase_q);
  end

  // Output decode; strobes are suppressed while held.
  always_comb begin
    strobe         = (state == STEP) && !bus.hold;
    bus.core_en    = strobe ? mask : '0;
    bus.node_sel   = strobe ? (NODES_PER_CORE'(1) << node) : '0;
    bus.phase      = phase_q;
    bus.iter_count = iter;
    bus.frame_busy = (state != IDLE);
    bus.frame_done = (state == DONE);
    bus.mouse_x    = mx_q;
    bus.mouse_y    = my_q;
    bus.overrun    = overrun_q;
  end

endmodule

// File: tb/tb_relax_scheduler.sv
// Scoreboard bench for relax_scheduler: a frame-level model queues the
// expected strobe sequence and completion time; a negedge monitor pops and
// compares whenever the DUT strobes or signals frame_done.
module tb_relax_scheduler;
  localparam int NC  = 4;
  localparam int NPC = 5;
  localparam int IT  = 8;
  localparam int SC  = 2;
  localparam int S   = 1 + SC;
  localparam int NSTROBE = IT * 2 * NPC;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   strobes = 0;
  bit   mon_en = 1'b0;

  typedef struct {
    int          t;
    logic [NC-1:0]  ce;
    logic [NPC-1:0] ns;
    logic [7:0]  it;
    logic        ph;
    logic [31:0] mx;
    logic [31:0] my;
  } strobe_t;

  strobe_t sq[$];
  int      dq[$];

  relax_scheduler_if #(.NUM_CORES(NC), .NODES_PER_CORE(NPC)) bi ();
  relax_scheduler_if #(.NUM_CORES(1), .NODES_PER_CORE(2)) bs ();

  relax_scheduler #(
    .NUM_CORES(NC), .NODES_PER_CORE(NPC),
    .ITERS_PER_FRAME(IT), .SETTLE_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .bus(bi.slave)
  );

  relax_scheduler #(
    .NUM_CORES(1), .NODES_PER_CORE(2),
    .ITERS_PER_FRAME(1), .SETTLE_CYCLES(0)
  ) dut_small (
    .clk(clk), .reset(reset), .bus(bs.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc + 1);
    end
  endtask

  // Monitor: cycle index of the current period is cyc+1.
  always @(negedge clk) begin
    if (mon_en) begin
      int cur;
      strobe_t e;
      cur = cyc + 1;
      check("onehot0", 64'($onehot0(bi.node_sel)), 64'd1);
      check("en_needs_sel", 64'(bi.core_en != 0 && bi.node_sel == 0), 64'd0);
      check("adjacent", 64'(bi.core_en & (bi.core_en >> 1)), 64'd0);
      if (bi.hold) check("en_in_hold", 64'(bi.core_en), 64'd0);
      if (bi.node_sel != 0) begin
        strobes++;
        if (sq.size() == 0) begin
          check("unexpected_strobe", 64'(bi.node_sel), 64'd0);
        end else begin
          e = sq.pop_front();
          check("strobe_time", 64'(cur), 64'(e.t));
          check("core_en", 64'(bi.core_en), 64'(e.ce));
          check("node_sel", 64'(bi.node_sel), 64'(e.ns));
          check("iter_count", 64'(bi.iter_count), 64'(e.it));
          check("phase", 64'(bi.phase), 64'(e.ph));
          check("mouse_x", 64'(bi.mouse_x), 64'(e.mx));
          check("mouse_y", 64'(bi.mouse_y), 64'(e.my));
        end
      end
      if (bi.frame_done) begin
        check("done_busy", 64'(bi.frame_busy), 64'd1);
        if (dq.size() == 0) check("unexpected_done", 64'd1, 64'd0);
        else check("done_time", 64'(cur), 64'(dq.pop_front()));
      end
    end
  end

  // Frame model: strobes at k+2+i*S; any strobe (and done) nominally at or
  // after the hold start cycle slips by the hold length.
  task automatic push_model(input int k, input logic [31:0] mx, input logic [31:0] my,
                            input int hc, input int hlen);
    int n = 0;
    logic [31:0] pat;
    strobe_t e;
    for (int it = 0; it < IT; it++)
      for (int ph = 0; ph < 2; ph++)
        for (int nd = 0; nd < NPC; nd++) begin
          e.t = k + 2 + n * S;
          if (e.t >= hc) e.t += hlen;
          pat = (ph == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
          e.ce = pat[NC-1:0];
          e.ns = NPC'(1) << nd;
          e.it = 8'(it);
          e.ph = ph[0];
          e.mx = mx;
          e.my = my;
          sq.push_back(e);
          n++;
        end
    dq.push_back(k + 2 + n * S + hlen);
  endtask

  task automatic run_frame(input logic [31:0] mx, input logic [31:0] my,
                           input int hoff, input int hlen, input bit ov);
    int k, hc, done_t, s0;
    bi.mouse_x_in = mx;
    bi.mouse_y_in = my;
    bi.frame_start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    bi.frame_start = 1'b0;
    s0 = strobes;
    hc = k + 2 + hoff;
    push_model(k, mx, my, hc, hlen);
    done_t = k + 2 + NSTROBE * S + hlen;
    check("latch_busy", 64'(bi.frame_busy), 64'd1);
    for (int cur = k + 2; cur <= done_t + 1; cur++) begin
      @(posedge clk); #1;
      bi.mouse_x_in = $urandom;
      bi.mouse_y_in = $urandom;
      bi.hold = (hlen > 0 && cur >= hc && cur < hc + hlen);
      bi.frame_start = ov && (cur == k + 50 || cur == done_t);
    end
    bi.hold = 1'b0;
    bi.frame_start = 1'b0;
    check("strobe_count", 64'(strobes - s0), 64'(NSTROBE));
    check("strobes_left", 64'(sq.size()), 64'd0);
    check("done_left", 64'(dq.size()), 64'd0);
    check("idle_busy", 64'(bi.frame_busy), 64'd0);
    check("idle_iter", 64'(bi.iter_count), 64'd0);
    check("idle_mouse_x", 64'(bi.mouse_x), 64'(mx));
    check("idle_mouse_y", 64'(bi.mouse_y), 64'(my));
  endtask

  initial begin
    int k, hoff, hlen;
    bi.frame_start = 1'b0; bi.hold = 1'b0; bi.mouse_x_in = '0; bi.mouse_y_in = '0;
    bs.frame_start = 1'b0; bs.hold = 1'b0; bs.mouse_x_in = '0; bs.mouse_y_in = '0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    check("rst_core_en", 64'(bi.core_en), 64'd0);
    check("rst_node_sel", 64'(bi.node_sel), 64'd0);
    check("rst_busy", 64'(bi.frame_busy), 64'd0);
    check("rst_done", 64'(bi.frame_done), 64'd0);
    check("rst_iter", 64'(bi.iter_count), 64'd0);
    check("rst_overrun", 64'(bi.overrun), 64'd0);
    check("rst_mouse_x", 64'(bi.mouse_x), 64'd0);
    check("rst_mouse_y", 64'(bi.mouse_y), 64'd0);
    mon_en = 1'b1;
    @(posedge clk); #1;

    // Plain frame, then hold for 10 cycles from the 3rd STEP.
    run_frame(32'h64, 32'hC8, 0, 0, 1'b0);
    run_frame(32'h1111_2222, 32'h3333_4444, 2 * S, 10, 1'b0);
    check("overrun_clear", 64'(bi.overrun), 64'd0);

    // Requests mid-frame and in DONE: overrun sticks, frame unaffected.
    run_frame(32'hDEAD_BEEF, 32'h0BAD_F00D, 0, 0, 1'b1);
    check("overrun_set", 64'(bi.overrun), 64'd1);
    run_frame(32'h5, 32'h6, 0, 0, 1'b0);
    check("overrun_sticky", 64'(bi.overrun), 64'd1);

    // Random frames with random hold windows (STEP or SETTLE start).
    for (int r = 0; r < 4; r++) begin
      hoff = $urandom_range(0, NSTROBE * S - 1);
      hlen = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 6) : 0;
      run_frame($urandom, $urandom, hoff, hlen, 1'b0);
    end

    // Reset in cycle k+100 aborts the frame.
    bi.mouse_x_in = 32'h1234; bi.mouse_y_in = 32'h5678;
    bi.frame_start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    bi.frame_start = 1'b0;
    push_model(k, 32'h1234, 32'h5678, k + 2, 0);
    repeat (98) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk); #1;
    sq.delete();
    dq.delete();
    check("abort_core_en", 64'(bi.core_en), 64'd0);
    check("abort_node_sel", 64'(bi.node_sel), 64'd0);
    check("abort_busy", 64'(bi.frame_busy), 64'd0);
    check("abort_iter", 64'(bi.iter_count), 64'd0);
    check("abort_overrun", 64'(bi.overrun), 64'd0);
    check("abort_mouse_x", 64'(bi.mouse_x), 64'd0);
    check("abort_done", 64'(bi.frame_done), 64'd0);
    @(posedge clk); #1 reset = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("abort_idle_busy", 64'(bi.frame_busy), 64'd0);

    // Minimal configuration: 4 strobes, second phase has an empty mask.
    bs.frame_start = 1'b1;
    @(posedge clk); #1;
    k = cyc;
    bs.frame_start = 1'b0;
    check("small_latch_busy", 64'(bs.frame_busy), 64'd1);
    for (int cur = k + 2; cur <= k + 7; cur++) begin
      int i;
      logic [1:0] ens;
      logic       ece;
      @(posedge clk); #1;
      i   = cur - k - 2;
      ens = (i >= 0 && i < 4) ? 2'(1 << (i % 2)) : 2'b00;
      ece = (i >= 0 && i < 2);
      check("small_node_sel", 64'(bs.node_sel), 64'(ens));
      check("small_core_en", 64'(bs.core_en), 64'(ece));
      if (i >= 0 && i < 4) check("small_phase", 64'(bs.phase), 64'(i / 2));
      check("small_done", 64'(bs.frame_done), 64'(cur == k + 6));
    end
    check("small_idle", 64'(bs.frame_busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
